// File: rtl/master_mux_sside_n_pkg.sv
// master_mux_sside_n_pkg: shared FSM states and grant field positions for the slave-side master mux
package master_mux_sside_n_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;
  localparam int GRANT_VALID = 0;
endpackage

// File: rtl/master_mux_sside_n_grant_decode.sv
// master_mux_sside_n_grant_decode: slave_grant -> legality flag and one-hot slave select
module master_mux_sside_n_grant_decode
  import master_mux_sside_n_pkg::*;
#(
  parameter int NUM_SLAVES = 3,
  parameter int GRANT_W    = 3
) (
  input  logic [GRANT_W-1:0]    slave_grant,
  output logic                  legal,
  output logic [NUM_SLAVES-1:0] onehot
);
  logic [GRANT_W-2:0] idx;
  assign idx   = slave_grant[GRANT_W-1:1];
  assign legal = slave_grant[GRANT_VALID] && idx != '0 && idx <= (GRANT_W-1)'(NUM_SLAVES);
  // one bit per slave, only when the code names a real slave
  always_comb begin
    onehot = '0;
    for (int k = 0; k < NUM_SLAVES; k++) onehot[k] = legal && idx == (GRANT_W-1)'(k + 1);
  end
endmodule

// File: rtl/master_mux_sside_n.sv
// master_mux_sside_n: registered slave-side master mux with grant lock and inter-grant drain
module master_mux_sside_n
  import master_mux_sside_n_pkg::*;
#(
  parameter int NUM_SLAVES   = 3,
  parameter int DATA_W       = 1,
  parameter int GRANT_W      = 3,
  parameter int DRAIN_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [GRANT_W-1:0]           slave_grant,
  input  logic                         to_slave_master_ready,
  input  logic                         to_slave_master_valid,
  input  logic                         to_slave_read_en,
  input  logic                         to_slave_write_en,
  input  logic [DATA_W-1:0]            to_slave_tx_address,
  input  logic [DATA_W-1:0]            to_slave_tx_data,
  input  logic                         to_slave_tx_burst,
  output logic [NUM_SLAVES-1:0]        s_master_ready,
  output logic [NUM_SLAVES-1:0]        s_master_valid,
  output logic [NUM_SLAVES-1:0]        s_read_en,
  output logic [NUM_SLAVES-1:0]        s_write_en,
  output logic [NUM_SLAVES*DATA_W-1:0] s_tx_address,
  output logic [NUM_SLAVES*DATA_W-1:0] s_tx_data,
  output logic [NUM_SLAVES-1:0]        s_tx_burst,
  output logic [NUM_SLAVES-1:0]        sel_onehot,
  output logic                         busy,
  output logic                         grant_err
);
  localparam int CW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [GRANT_W-1:0]    code, code_n;
  logic [NUM_SLAVES-1:0] sel_n, onehot;
  logic                  legal, err_n;
  master_mux_sside_n_grant_decode #(.NUM_SLAVES(NUM_SLAVES), .GRANT_W(GRANT_W)) u_dec (
    .slave_grant(slave_grant),
    .legal(legal),
    .onehot(onehot)
  );
  // next state; sel_n is the slave to drive after this edge (zero unless locked)
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    code_n  = code;
    sel_n   = '0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (legal) begin
          state_n = ACTIVE;
          code_n  = slave_grant;
          sel_n   = onehot;
        end
        err_n = slave_grant[GRANT_VALID] & ~legal;
      end
      ACTIVE: begin
        if (slave_grant == code) sel_n = sel_onehot;
        else begin
          state_n = DRAIN;
          cnt_n   = CW'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (cnt == '0) state_n = IDLE;
        else cnt_n = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  // control registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      code       <= '0;
      sel_onehot <= '0;
      busy       <= 1'b0;
      grant_err  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      code       <= code_n;
      sel_onehot <= sel_n;
      busy       <= state_n != IDLE;
      grant_err  <= err_n;
    end
  end
  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slave
    // per-slave copy of the master request, zero unless this slave is selected
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        s_master_ready[g]                 <= 1'b0;
        s_master_valid[g]                 <= 1'b0;
        s_read_en[g]                      <= 1'b0;
        s_write_en[g]                     <= 1'b0;
        s_tx_burst[g]                     <= 1'b0;
        s_tx_address[g*DATA_W +: DATA_W]  <= '0;
        s_tx_data[g*DATA_W +: DATA_W]     <= '0;
      end else begin
        s_master_ready[g]                 <= sel_n[g] & to_slave_master_ready;
        s_master_valid[g]                 <= sel_n[g] & to_slave_master_valid;
        s_read_en[g]                      <= sel_n[g] & to_slave_read_en;
        s_write_en[g]                     <= sel_n[g] & to_slave_write_en;
        s_tx_burst[g]                     <= sel_n[g] & to_slave_tx_burst;
        s_tx_address[g*DATA_W +: DATA_W]  <= sel_n[g] ? to_slave_tx_address : '0;
        s_tx_data[g*DATA_W +: DATA_W]     <= sel_n[g] ? to_slave_tx_data : '0;
      end
    end
  end
endmodule
